// File: rtl/b2m_zerofix_d2_pkg.sv
// Shared constants for the 3-share Boolean-to-multiplicative conversion stage.
// Holds the rnd field layout and the end-to-end pipeline depth helper.
package b2m_zerofix_d2_pkg;

  localparam logic [8:0] AES_POLY = 9'h11B;

  localparam int SHARE_W = 8;
  localparam int NSHARES = 3;
  localparam int RND_W   = 40;

  // rnd = {f2, f1, f0, R2, R1}
  localparam int RND_R1_OFF = 0;
  localparam int RND_R2_OFF = 8;
  localparam int RND_F0_OFF = 16;
  localparam int RND_F1_OFF = 24;
  localparam int RND_F2_OFF = 32;

  function automatic int pipe_depth(input int kron_lat);
    return kron_lat + 3;
  endfunction

endpackage

// File: rtl/b2m_zerofix_d2_gf256_mul.sv
// Combinational GF(2^8) multiplier, shift-and-add with reduction modulo POLY.
module b2m_zerofix_d2_gf256_mul
  import b2m_zerofix_d2_pkg::*;
#(
  parameter logic [8:0] POLY = AES_POLY
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY[7:0] : 8'h00);
    end
  end

  assign y = acc;

endmodule

// File: rtl/b2m_zerofix_d2.sv
// Second-order Boolean-to-multiplicative conversion with x=0 lifted to 1 using
// the kronecker_d2 zero-flag; delta shares are forwarded aligned with p.
module b2m_zerofix_d2
  import b2m_zerofix_d2_pkg::*;
#(
  parameter int         KRON_LAT = 2,
  parameter logic [8:0] POLY     = AES_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] shared_inp,
  input  logic [2:0]  kron_in,
  input  logic [39:0] rnd,
  output logic        out_valid,
  output logic [7:0]  p,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [2:0]  delta_out
);

  function automatic logic [7:0] sanitise_mask(input logic [7:0] m);
    return (m == 8'h00) ? 8'h01 : m;
  endfunction

  // Delay line aligning shared_inp with kron_in
  logic        dly_vld_q [KRON_LAT];
  logic        dly_vld_d [KRON_LAT];
  logic [23:0] dly_sh_q  [KRON_LAT];
  logic [23:0] dly_sh_d  [KRON_LAT];

  always_comb begin
    dly_vld_d[0] = in_valid;
    dly_sh_d[0]  = shared_inp;
    for (int i = 1; i < KRON_LAT; i++) begin
      dly_vld_d[i] = dly_vld_q[i-1];
      dly_sh_d[i]  = dly_sh_q[i-1];
    end
  end

  // Stage T: zero-fix, mask sanitising, first masking products
  logic              vld_p0;
  logic signed [7:0] unused_sign;
  logic [23:0]       sh_p0;
  logic [7:0]        xs0_p0, xs1_p0, xs2_p0;
  logic [7:0]        r1_p0, r2_p0, f0_p0, f1_p0, f2_p0;
  logic [7:0]        m0_p0, m1_p0, m2_p0;

  assign unused_sign = '0;
  assign vld_p0 = dly_vld_q[KRON_LAT-1];
  assign sh_p0  = dly_sh_q[KRON_LAT-1];
  assign xs0_p0 = sh_p0[7:0]   ^ {7'b0, kron_in[0]};
  assign xs1_p0 = sh_p0[15:8]  ^ {7'b0, kron_in[1]};
  assign xs2_p0 = sh_p0[23:16] ^ {7'b0, kron_in[2]};
  assign r1_p0  = sanitise_mask(rnd[RND_R1_OFF +: SHARE_W]);
  assign r2_p0  = sanitise_mask(rnd[RND_R2_OFF +: SHARE_W]);
  assign f0_p0  = rnd[RND_F0_OFF +: SHARE_W];
  assign f1_p0  = rnd[RND_F1_OFF +: SHARE_W];
  assign f2_p0  = rnd[RND_F2_OFF +: SHARE_W];

  b2m_zerofix_d2_gf256_mul #(.POLY(POLY)) u_mul_s1_0 (.a(xs0_p0), .b(r1_p0), .y(m0_p0));
  b2m_zerofix_d2_gf256_mul #(.POLY(POLY)) u_mul_s1_1 (.a(xs1_p0), .b(r1_p0), .y(m1_p0));
  b2m_zerofix_d2_gf256_mul #(.POLY(POLY)) u_mul_s1_2 (.a(xs2_p0), .b(r1_p0), .y(m2_p0));

  logic       vld_p1_q, vld_p1_d;
  logic [7:0] u0_p1_q, u0_p1_d, u1_p1_q, u1_p1_d, u2_p1_q, u2_p1_d;
  logic [7:0] r1_p1_q, r1_p1_d, r2_p1_q, r2_p1_d, f2_p1_q, f2_p1_d;
  logic [2:0] k_p1_q, k_p1_d;

  // Each refresh byte is shared between two neighbouring shares so the sum cancels
  always_comb begin
    vld_p1_d = vld_p0;
    u0_p1_d  = m0_p0 ^ f0_p0;
    u1_p1_d  = m1_p0 ^ f0_p0 ^ f1_p0;
    u2_p1_d  = m2_p0 ^ f1_p0;
    r1_p1_d  = r1_p0;
    r2_p1_d  = r2_p0;
    f2_p1_d  = f2_p0;
    k_p1_d   = kron_in;
  end

  // Stage 1 -> 2: fold of refreshed shares and second masking products
  logic [7:0] uf_p1, m3_p1, m4_p1;

  assign uf_p1 = u0_p1_q ^ u2_p1_q;

  b2m_zerofix_d2_gf256_mul #(.POLY(POLY)) u_mul_s2_0 (.a(uf_p1),   .b(r2_p1_q), .y(m3_p1));
  b2m_zerofix_d2_gf256_mul #(.POLY(POLY)) u_mul_s2_1 (.a(u1_p1_q), .b(r2_p1_q), .y(m4_p1));

  logic       vld_p2_q, vld_p2_d;
  logic [7:0] v0_p2_q, v0_p2_d, v1_p2_q, v1_p2_d;
  logic [7:0] r1_p2_q, r1_p2_d, r2_p2_q, r2_p2_d;
  logic [2:0] k_p2_q, k_p2_d;

  always_comb begin
    vld_p2_d = vld_p1_q;
    v0_p2_d  = m3_p1 ^ f2_p1_q;
    v1_p2_d  = m4_p1 ^ f2_p1_q;
    r1_p2_d  = r1_p1_q;
    r2_p2_d  = r2_p1_q;
    k_p2_d   = k_p1_q;
  end

  // Stage 2 -> 3: recombine into the public share
  logic       vld_p3_q, vld_p3_d;
  logic [7:0] p_p3_q, p_p3_d, r1_p3_q, r1_p3_d, r2_p3_q, r2_p3_d;
  logic [2:0] k_p3_q, k_p3_d;

  always_comb begin
    vld_p3_d = vld_p2_q;
    p_p3_d   = v0_p2_q ^ v1_p2_q;
    r1_p3_d  = r1_p2_q;
    r2_p3_d  = r2_p2_q;
    k_p3_d   = k_p2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KRON_LAT; i++) dly_vld_q[i] <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      p_p3_q   <= 8'h00;
      r1_p3_q  <= 8'h00;
      r2_p3_q  <= 8'h00;
      k_p3_q   <= 3'b000;
    end else begin
      for (int i = 0; i < KRON_LAT; i++) dly_vld_q[i] <= dly_vld_d[i];
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      p_p3_q   <= p_p3_d;
      r1_p3_q  <= r1_p3_d;
      r2_p3_q  <= r2_p3_d;
      k_p3_q   <= k_p3_d;
    end
  end

  // Internal data registers carry no reset; their content is qualified by valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < KRON_LAT; i++) dly_sh_q[i] <= dly_sh_d[i];
    u0_p1_q <= u0_p1_d;
    u1_p1_q <= u1_p1_d;
    u2_p1_q <= u2_p1_d;
    r1_p1_q <= r1_p1_d;
    r2_p1_q <= r2_p1_d;
    f2_p1_q <= f2_p1_d;
    k_p1_q  <= k_p1_d;
    v0_p2_q <= v0_p2_d;
    v1_p2_q <= v1_p2_d;
    r1_p2_q <= r1_p2_d;
    r2_p2_q <= r2_p2_d;
    k_p2_q  <= k_p2_d;
  end

  assign out_valid = vld_p3_q;
  assign p         = p_p3_q;
  assign r1        = r1_p3_q;
  assign r2        = r2_p3_q;
  assign delta_out = k_p3_q;

endmodule

// File: tb/tb_b2m_zerofix_d2.sv
// Directed-vector bench for b2m_zerofix_d2: a per-cycle schedule of inputs,
// with every output cycle compared against hand values and a GF(2^8) model.
module tb_b2m_zerofix_d2;
  import b2m_zerofix_d2_pkg::*;

  localparam int KL  = 2;
  localparam int LAT = pipe_depth(KL);
  localparam int NC  = 300 + LAT + 2;
  localparam int MI_LO = 40;
  localparam int MI_HI = 295;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] shared_inp = '0;
  logic [2:0]  kron_in = '0;
  logic [39:0] rnd = '0;
  logic        out_valid;
  logic [7:0]  p, r1, r2;
  logic [2:0]  delta_out;

  b2m_zerofix_d2 #(.KRON_LAT(KL), .POLY(9'h11B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .shared_inp(shared_inp),
    .kron_in(kron_in), .rnd(rnd), .out_valid(out_valid), .p(p), .r1(r1),
    .r2(r2), .delta_out(delta_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Carry-less product then polynomial reduction from the top bit down
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'(a) << i);
    for (int j = 14; j >= 8; j--)
      if (prod[j]) prod = prod ^ (15'h11B << (j - 8));
    return prod[7:0];
  endfunction

  logic        s_vld [NC];
  logic        s_rst [NC];
  logic [23:0] s_sh  [NC];
  logic [2:0]  s_k   [NC];
  logic [39:0] s_rnd [NC];
  logic        s_hand[NC];
  logic [7:0]  s_hp  [NC];
  logic [7:0]  s_hr1 [NC];
  logic [7:0]  s_hr2 [NC];
  logic        seen  [256];

  function automatic logic [23:0] make_sh(input logic [7:0] x);
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    return {x ^ a ^ b, b, a};
  endfunction

  function automatic logic [2:0] make_k(input logic d);
    logic [2:0] k;
    k = 3'($urandom);
    k[2] = d ^ k[0] ^ k[1];
    return k;
  endfunction

  function automatic logic [39:0] make_rnd(input logic [7:0] m1, input logic [7:0] m2);
    return {8'($urandom), 8'($urandom), 8'($urandom), m2, m1};
  endfunction

  function automatic logic dropped(input int o);
    for (int r = o; r < o + LAT; r++)
      if (r < NC && s_rst[r]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [7:0] x, xp, m1, m2, ep;
    logic       ev;
    int         o, distinct;

    for (int c = 0; c < NC; c++) begin
      s_vld[c] = 0; s_rst[c] = (c < 3); s_sh[c] = '0; s_k[c] = '0;
      s_rnd[c] = '0; s_hand[c] = 0; s_hp[c] = '0; s_hr1[c] = '0; s_hr2[c] = '0;
    end
    for (int i = 0; i < 256; i++) seen[i] = 0;

    // Zero operand lifted to 1: p = 1*02*03
    s_vld[4] = 1; s_sh[4] = 24'h86A325; s_k[4] = 3'b100; s_rnd[4] = make_rnd(8'h02, 8'h03);
    s_hand[4] = 1; s_hp[4] = 8'h06; s_hr1[4] = 8'h02; s_hr2[4] = 8'h03;
    // Trivial masks
    s_vld[5] = 1; s_sh[5] = make_sh(8'h53); s_k[5] = 3'b011; s_rnd[5] = make_rnd(8'h01, 8'h01);
    s_hand[5] = 1; s_hp[5] = 8'h53; s_hr1[5] = 8'h01; s_hr2[5] = 8'h01;
    // 53 * CA = 01 in the AES field
    s_vld[6] = 1; s_sh[6] = make_sh(8'h53); s_k[6] = 3'b101; s_rnd[6] = make_rnd(8'hCA, 8'h01);
    s_hand[6] = 1; s_hp[6] = 8'h01; s_hr1[6] = 8'hCA; s_hr2[6] = 8'h01;
    // Zero masks become 01
    s_vld[7] = 1; s_sh[7] = make_sh(8'h53); s_k[7] = 3'b110; s_rnd[7] = make_rnd(8'h00, 8'h00);
    s_hand[7] = 1; s_hp[7] = 8'h53; s_hr1[7] = 8'h01; s_hr2[7] = 8'h01;
    // Streaming burst with two zero operands
    for (int c = 10; c < 20; c++) begin
      x = (c == 13 || c == 17) ? 8'h00 : 8'($urandom_range(1, 255));
      s_vld[c] = 1; s_sh[c] = make_sh(x); s_k[c] = make_k(x == 8'h00);
      s_rnd[c] = {$urandom, 8'($urandom)};
    end
    // Bubble, then reset between second and third operand
    for (int c = 30; c <= 34; c += 2) begin
      x = 8'($urandom);
      s_vld[c] = 1; s_sh[c] = make_sh(x); s_k[c] = make_k(x == 8'h00);
      s_rnd[c] = {$urandom, 8'($urandom)};
    end
    s_rst[33] = 1;
    // Mask independence on x = 0
    for (int c = MI_LO; c <= MI_HI; c++) begin
      s_vld[c] = 1; s_sh[c] = make_sh(8'h00); s_k[c] = make_k(1'b1);
      s_rnd[c] = {$urandom, 8'($urandom)};
    end

    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      if (c >= 1 && s_rst[c-1]) begin
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_p", 32'(p), 32'd0);
        check_eq("rst_r1", 32'(r1), 32'd0);
        check_eq("rst_r2", 32'(r2), 32'd0);
        check_eq("rst_delta", 32'(delta_out), 32'd0);
      end else if (c >= 1) begin
        o  = c - LAT;
        ev = (o >= 0) && s_vld[o] && !dropped(o);
        check_eq("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
          xp = s_sh[o][7:0] ^ s_sh[o][15:8] ^ s_sh[o][23:16] ^ {7'b0, ^s_k[o]};
          m1 = (s_rnd[o][7:0]  == 8'h00) ? 8'h01 : s_rnd[o][7:0];
          m2 = (s_rnd[o][15:8] == 8'h00) ? 8'h01 : s_rnd[o][15:8];
          ep = gmul(gmul(xp, m1), m2);
          check_eq("p_model", 32'(p), 32'(ep));
          check_eq("r1_model", 32'(r1), 32'(m1));
          check_eq("r2_model", 32'(r2), 32'(m2));
          check_eq("delta_out", 32'(delta_out), 32'(s_k[o]));
          check_eq("p_nonzero", 32'(p != 8'h00), 32'd1);
          if (s_hand[o]) begin
            check_eq("p_hand", 32'(p), 32'(s_hp[o]));
            check_eq("r1_hand", 32'(r1), 32'(s_hr1[o]));
            check_eq("r2_hand", 32'(r2), 32'(s_hr2[o]));
          end
          if (o >= MI_LO && o <= MI_HI) seen[p] = 1'b1;
        end
      end
      in_valid   = s_vld[c];
      rst        = s_rst[c];
      shared_inp = s_sh[c];
      kron_in    = (c >= KL) ? s_k[c-KL]   : 3'b000;
      rnd        = (c >= KL) ? s_rnd[c-KL] : 40'h0;
    end

    distinct = 0;
    for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
    check_eq("mi_p_never_zero", 32'(seen[0]), 32'd0);
    check_eq("mi_p_spread", 32'(distinct >= 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/b2m_zerofix_d2.md
Name: b2m_zerofix_d2

Overview:
- Second-order (3-share) Boolean-to-multiplicative conversion stage of the masked AES S-box.
- Sits directly downstream of kronecker_d2 and consumes its 3-share zero-flag.
- Uses the flag to lift x=0 to x'=1, so x' = x ^ δ(x) is always nonzero.
- Converts x' into multiplicative shares (p, r1, r2) for the masked inversion.
- Forwards the delta shares, aligned to the output, for the post-inversion correction.

Parameters:
KRON_LAT, 2, cycles between a shared_inp sample and the matching kronecker_d2 output on kron_in; legal range ≥1.
POLY, 9'h11B, GF(2^8) reduction polynomial (AES).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  shared_inp carries a new operand this cycle
shared_inp  in  24  Boolean shares {s2,s1,s0}, 8 bits each; x = s0^s1^s2
kron_in  in  3  kronecker_d2 output shares; δ(x) = k0^k1^k2
rnd  in  40  {f2,f1,f0,R2,R1}, 8 bits each; sampled together with kron_in
out_valid  out  1  outputs valid
p  out  8  public multiplicative share
r1  out  8  mask 1
r2  out  8  mask 2; x' = p·r1⁻¹·r2⁻¹
delta_out  out  3  kron_in shares delayed to align with p

Behaviour:
- Reset: all valid bits and all outputs are 0. Output registers are cleared on rst, not held.
- Reset mid-operation drops all in-flight operands. The first out_valid after reset comes from an in_valid sampled after rst deasserts.
- Delay line:
  - KRON_LAT-deep shift register of {in_valid, shared_inp}.
  - Entry at depth KRON_LAT is combined with kron_in and rnd in the same cycle (call it cycle T).
- Fully pipelined: one new operand per cycle, no stalls, no backpressure.
- Latency: out_valid rises exactly KRON_LAT+3 cycles after the cycle in which in_valid=1 was sampled.
- Mask sanitising: R1 or R2 equal to 8'h00 is replaced by 8'h01. Masks are always nonzero; this bias is accepted.
- Stage 1 (registered at T+1):
  - zero-fix: x'_j = s_j ^ {7'b0, k_j} for j = 0..2.
  - u0 = x'0·R1 ^ f0
  - u1 = x'1·R1 ^ f0 ^ f1
  - u2 = x'2·R1 ^ f1
  - Register R1, R2, f2 and k alongside.
- Stage 2 (registered at T+2):
  - v0 = (u0 ^ u2)·R2 ^ f2
  - v1 = u1·R2 ^ f2
- Stage 3 (registered at T+3):
  - p = v0 ^ v1
  - r1, r2 = the sanitised masks used for this operand
  - delta_out = k
- All products are GF(2^8) multiplications modulo POLY.
- Share hygiene:
  - No combinational expression may mix two shares of the same operand before they have been multiplied by R1 and refreshed.
  - The only fold of unrefreshed shares is the stage-2 u0^u2, which is already masked by f0/f1 and R1.
  - u0 ^ u2 is a register-to-register path within stage 2.
- in_valid=0 bubbles propagate as out_valid=0. Data registers may still update, but their content is don't-care when valid=0.
- Back-to-back operands must not interfere: each uses its own rnd sample.

Decomposition:
- Shared package:
  - POLY constant
  - SHARE_W=8, NSHARES=3, RND_W=40 constants
  - rnd field offsets (R1, R2, f0, f1, f2)
  - total pipeline depth function KRON_LAT+3
- Sub-module gf256_mul: combinational 8×8 GF(2^8) multiplier modulo POLY. Five instances: 3 in stage 1, 2 in stage 2.
- Delay line, mask sanitiser and stages stay inline.

Test Plan:
- Zero input:
  - Stimulus: shared_inp=24'h86A325 (x=0); at T, kron_in=3'b100, R1=02, R2=03, f*=random.
  - Required at T+3: p=8'h06, r1=02, r2=03, delta_out=3'b100, and p·r1⁻¹·r2⁻¹=01.
- Nonzero, trivial masks:
  - Stimulus: x=8'h53 with random shares; kron_in xor=0 (e.g. 3'b011); R1=R2=01.
  - Required: p=8'h53.
  - Repeat with R1=8'hCA, R2=01 → required p=8'h01.
- Zero masks: R1=00, R2=00, x=8'h53 → required r1=r2=01, p=8'h53.
- Streaming:
  - Stimulus: 10 consecutive in_valid, random x (including two zeros), random rnd and refresh bytes.
  - Required: out_valid high for 10 consecutive cycles starting KRON_LAT+3 after the first in_valid.
  - Every output reconstructs x^δ(x). delta_out xor matches δ(x).
- Bubbles and reset:
  - Stimulus: in_valid pattern 1,0,1; assert rst for one cycle between the second and third operand.
  - Required: outputs and out_valid are 0 the cycle after rst. Only the third operand appears, at its nominal latency.
- Mask independence:
  - Stimulus: same x=8'h00 repeated 256 times with uniformly random rnd.
  - Required: p distribution over nonzero values, never 00. r1 and r2 are never 00.
